// File: rtl/data_memory_initiator_if.sv
// data_memory_initiator_if: request/response handshake plus data-memory bus control signals
interface data_memory_initiator_if #(parameter int ADDR_WIDTH = 32);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [1:0] req_size;
  logic req_unsigned;
  logic [ADDR_WIDTH-1:0] req_address;
  logic [31:0] req_wdata;
  logic resp_valid;
  logic [31:0] resp_rdata;
  logic resp_error;
  logic data_memory_interface_enable;
  logic data_memory_interface_state;
  logic [ADDR_WIDTH-1:0] data_memory_interface_address;
  logic [3:0] data_memory_interface_frame_mask;
  modport master (
    input req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output data_memory_interface_enable, data_memory_interface_state,
    output data_memory_interface_address, data_memory_interface_frame_mask
  );
  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_address, req_wdata,
    input req_ready, resp_valid, resp_rdata, resp_error,
    input data_memory_interface_enable, data_memory_interface_state,
    input data_memory_interface_address, data_memory_interface_frame_mask
  );
endinterface

// File: rtl/data_memory_initiator.sv
// data_memory_initiator: single-request load/store master for the data memory bus; MISALIGN_CHECK_EN turns misalignment into error responses
module data_memory_initiator #(
  parameter int ACCESS_CYCLES = 1,
  parameter int ADDR_WIDTH = 32
) (
  input logic clk,
  input logic reset,
  data_memory_initiator_if.master bus,
  inout wire [31:0] data_memory_interface_data
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;
  localparam logic READ = 1'b0;
  localparam logic WRITE = 1'b1;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic wr_q, uns_q, err_q, accept, bad;
  logic [1:0] size_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_m;
  logic [31:0] wdata_q, rdata_q, sh, ext;
  logic [3:0] fmask;
  assign accept = bus.req_valid && bus.req_ready;
`ifdef MISALIGN_CHECK_EN
  assign bad = (bus.req_size == 2'b01 && bus.req_address[0]) || (bus.req_size[1] && |bus.req_address[1:0]);
  assign addr_m = bus.req_address;
`else
  assign bad = 1'b0;
  assign addr_m = bus.req_address & {{(ADDR_WIDTH-2){1'b1}}, ~bus.req_size[1], ~|bus.req_size};
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
      uns_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt <= 4'(ACCESS_CYCLES - 1);
        wr_q <= bus.req_write;
        uns_q <= bus.req_unsigned;
        err_q <= bad;
        size_q <= bus.req_size;
        addr_q <= addr_m;
        wdata_q <= bus.req_wdata;
      end else if (state == ACCESS) begin
        cnt <= cnt - 4'd1;
        if (cnt == '0 && !wr_q) rdata_q <= data_memory_interface_data;
      end
    end
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (accept ? (bad ? RESPOND : ACCESS) : IDLE) :
               state == ACCESS ? (cnt == '0 ? RESPOND : ACCESS) : IDLE;
  end
  assign fmask = size_q == 2'b00 ? 4'b1000 >> addr_q[1:0] :
                 size_q == 2'b01 ? (addr_q[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign sh = rdata_q >> {addr_q[1:0], 3'b000};
  assign ext = size_q == 2'b00 ? {{24{~uns_q & sh[7]}}, sh[7:0]} :
               size_q == 2'b01 ? {{16{~uns_q & sh[15]}}, sh[15:0]} : sh;
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESPOND;
  assign bus.resp_error = state == RESPOND && err_q;
  assign bus.resp_rdata = (state == RESPOND && !wr_q && !err_q) ? ext : '0;
  assign bus.data_memory_interface_enable = state == ACCESS;
  assign bus.data_memory_interface_state = (state == ACCESS && wr_q) ? WRITE : READ;
  assign bus.data_memory_interface_address = state == ACCESS ? addr_q : '0;
  assign bus.data_memory_interface_frame_mask = state == ACCESS ? fmask : 4'b0000;
  assign data_memory_interface_data = (state == ACCESS && wr_q) ? wdata_q << {addr_q[1:0], 3'b000} : 32'bz;
endmodule

// File: tb/tb_data_memory_initiator.sv
// tb_data_memory_initiator: table, random and hand-written sequences against a byte-level memory model
module tb_data_memory_initiator;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  data_memory_initiator_if #(.ADDR_WIDTH(32)) i1 ();
  data_memory_initiator_if #(.ADDR_WIDTH(32)) i3 ();
  wire [31:0] d1, d3;
  logic drv1 = 1'b0, drv3 = 1'b0, probe1 = 1'b0, probe3 = 1'b0;
  logic [31:0] val1 = '0;
  assign d1 = (drv1 | probe1) ? (probe1 ? 32'h0 : val1) : 32'bz;
  assign d3 = (drv3 | probe3) ? (probe3 ? 32'h0 : 32'hCAFEF00D) : 32'bz;
  data_memory_initiator #(.ACCESS_CYCLES(1), .ADDR_WIDTH(32)) u1 (
    .clk(clk), .reset(reset), .bus(i1.master), .data_memory_interface_data(d1));
  data_memory_initiator #(.ACCESS_CYCLES(3), .ADDR_WIDTH(32)) u3 (
    .clk(clk), .reset(reset), .bus(i3.master), .data_memory_interface_data(d3));
  logic [31:0] bus_mem [0:1023];
  logic [7:0] ref_mem [0:4095];
  int n_cmp = 0, n_err = 0;
  always @(negedge clk) begin
    drv1 <= i1.data_memory_interface_enable && !i1.data_memory_interface_state;
    val1 <= bus_mem[i1.data_memory_interface_address[11:2]];
    drv3 <= i3.data_memory_interface_enable && !i3.data_memory_interface_state;
  end
  always @(posedge clk)
    if (i1.data_memory_interface_enable && i1.data_memory_interface_state)
      for (int k = 0; k < 4; k++)
        if (i1.data_memory_interface_frame_mask[3-k])
          bus_mem[i1.data_memory_interface_address[11:2]][8*k +: 8] <= d1[8*k +: 8];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic check_reset_state(input string nm);
    check({nm, "_ready"}, i1.req_ready, 1);
    check({nm, "_rvalid"}, i1.resp_valid | i3.resp_valid, 0);
    check({nm, "_rdata"}, i1.resp_rdata | i3.resp_rdata, 0);
    check({nm, "_err"}, i1.resp_error | i3.resp_error, 0);
    check({nm, "_en"}, i1.data_memory_interface_enable | i3.data_memory_interface_enable, 0);
    check({nm, "_state"}, i3.data_memory_interface_state, 0);
    check({nm, "_addr"}, i3.data_memory_interface_address, 0);
    check({nm, "_mask"}, i3.data_memory_interface_frame_mask, 0);
    probe1 = 1'b1;
    probe3 = 1'b1;
    #1;
    check({nm, "_hiz1"}, d1, 0);
    check({nm, "_hiz3"}, d3, 0);
    probe1 = 1'b0;
    probe3 = 1'b0;
  endtask
  task automatic run1(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                      input logic [31:0] wd, input bit has_exp, input logic [31:0] exp_rd,
                      input logic [3:0] exp_mask);
    int n, off;
    bit err;
    logic [31:0] eff, ex_rd;
    logic [3:0] ex_mask;
    longint v;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
    err = 1'b0;
`ifdef MISALIGN_CHECK_EN
    err = (a % n) != 0;
`endif
    eff = a - (a % n);
    off = int'(eff % 4);
    ex_mask = '0;
    for (int k = 0; k < n; k++) ex_mask[3-(off+k)] = 1'b1;
    ex_rd = '0;
    if (!w && !err) begin
      v = 0;
      for (int k = 0; k < n; k++) v = v | (longint'(ref_mem[eff+k]) << (8*k));
      if (!u && n < 4 && v[8*n-1]) v = v - (64'd1 << (8*n));
      ex_rd = 32'(v);
    end
    if (w && !err) for (int k = 0; k < n; k++) ref_mem[eff+k] = wd[8*k +: 8];
    if (has_exp) begin
      ex_rd = exp_rd;
      ex_mask = exp_mask;
    end
    @(negedge clk);
    i1.req_valid = 1'b1;
    i1.req_write = w;
    i1.req_size = sz;
    i1.req_unsigned = u;
    i1.req_address = a;
    i1.req_wdata = wd;
    check("accept_ready", i1.req_ready, 1);
    @(posedge clk);
    #1;
    i1.req_valid = 1'b0;
    i1.req_write = 1'($urandom);
    i1.req_size = 2'($urandom);
    i1.req_address = $urandom;
    i1.req_wdata = $urandom;
    if (err) begin
      @(negedge clk);
      check("mis_en", i1.data_memory_interface_enable, 0);
      check("mis_rvalid", i1.resp_valid, 1);
      check("mis_err", i1.resp_error, 1);
      check("mis_rdata", i1.resp_rdata, 0);
    end else begin
      @(negedge clk);
      check("acc_en", i1.data_memory_interface_enable, 1);
      check("acc_rvalid", i1.resp_valid, 0);
      check("acc_state", i1.data_memory_interface_state, w);
      check("acc_addr", i1.data_memory_interface_address, eff);
      check("acc_mask", i1.data_memory_interface_frame_mask, ex_mask);
      if (w) for (int k = 0; k < n; k++) check("acc_lane", (d1 >> (8*(off+k))) & 32'hFF, wd[8*k +: 8]);
      @(negedge clk);
      check("rsp_en", i1.data_memory_interface_enable, 0);
      check("rsp_valid", i1.resp_valid, 1);
      check("rsp_err", i1.resp_error, 0);
      check("rsp_rdata", i1.resp_rdata, ex_rd);
      if (w) begin
        probe1 = 1'b1;
        #1;
        check("rsp_hiz", d1, 0);
        probe1 = 1'b0;
      end
    end
    @(negedge clk);
    check("post_rvalid", i1.resp_valid, 0);
    check("post_ready", i1.req_ready, 1);
  endtask
  typedef struct {
    bit w;
    logic [1:0] sz;
    bit u;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [3:0] mask;
  } vec_t;
  vec_t tbl [12];
  initial begin
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 4'b1111};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 32'h103, 32'h000000A5, 32'h0, 4'b0001};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'hFFFFFFA5, 4'b0001};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h000000A5, 4'b0001};
    tbl[4]  = '{1'b1, 2'd2, 1'b0, 32'h200, 32'h80017FFF, 32'h0, 4'b1111};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h200, 32'h0, 32'h00007FFF, 4'b1100};
    tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h202, 32'h0, 32'hFFFF8001, 4'b0011};
`ifdef MISALIGN_CHECK_EN
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 4'b1111};
`else
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'hA5ADBEEF, 4'b1111};
`endif
    tbl[8]  = '{1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 32'h00008001, 4'b0011};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 32'h201, 32'h0, 32'h0000007F, 4'b0100};
    tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h202, 32'h00001234, 32'h0, 4'b0011};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 32'h12347FFF, 4'b1111};
    for (int i = 0; i < 1024; i++) bus_mem[i] = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    i1.req_valid = 1'b0; i1.req_write = 1'b0; i1.req_size = '0; i1.req_unsigned = 1'b0;
    i1.req_address = '0; i1.req_wdata = '0;
    i3.req_valid = 1'b0; i3.req_write = 1'b0; i3.req_size = '0; i3.req_unsigned = 1'b0;
    i3.req_address = '0; i3.req_wdata = '0;
    #3;
    check_reset_state("reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++)
      run1(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].a, tbl[i].wd, 1'b1, tbl[i].rd, tbl[i].mask);
    for (int i = 0; i < 150; i++)
      run1(1'($urandom), 2'($urandom), 1'($urandom), 32'h100 + ($urandom % 32), $urandom, 1'b0, '0, '0);
    @(negedge clk);
    i3.req_valid = 1'b1; i3.req_write = 1'b0; i3.req_size = 2'd2; i3.req_unsigned = 1'b0;
    i3.req_address = 32'h40;
    check("ac3_ready0", i3.req_ready, 1);
    @(posedge clk);
    #1;
    i3.req_size = 2'd0; i3.req_unsigned = 1'b1; i3.req_address = 32'h41;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("ac3_en", i3.data_memory_interface_enable, 1);
      check("ac3_busy", i3.req_ready, 0);
      check("ac3_early", i3.resp_valid, 0);
    end
    @(negedge clk);
    check("ac3_en_off", i3.data_memory_interface_enable, 0);
    check("ac3_rvalid", i3.resp_valid, 1);
    check("ac3_rdata", i3.resp_rdata, 32'hCAFEF00D);
    check("ac3_rsp_busy", i3.req_ready, 0);
    @(negedge clk);
    check("ac3_gap_ready", i3.req_ready, 1);
    check("ac3_gap_en", i3.data_memory_interface_enable, 0);
    check("ac3_gap_rvalid", i3.resp_valid, 0);
    @(posedge clk);
    #1;
    i3.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("ac3b_en", i3.data_memory_interface_enable, 1);
      check("ac3b_addr", i3.data_memory_interface_address, 32'h41);
      check("ac3b_mask", i3.data_memory_interface_frame_mask, 4'b0100);
    end
    @(negedge clk);
    check("ac3b_rvalid", i3.resp_valid, 1);
    check("ac3b_rdata", i3.resp_rdata, 32'h000000F0);
    @(negedge clk);
    check("ac3b_done", i3.resp_valid, 0);
    i3.req_valid = 1'b1; i3.req_write = 1'b1; i3.req_size = 2'd2; i3.req_address = 32'h80;
    i3.req_wdata = 32'h11223344;
    @(posedge clk);
    #1;
    i3.req_valid = 1'b0;
    @(negedge clk);
    check("rst_c1_en", i3.data_memory_interface_enable, 1);
    @(negedge clk);
    check("rst_c2_en", i3.data_memory_interface_enable, 1);
    check("rst_c2_state", i3.data_memory_interface_state, 1);
    check("rst_c2_data", d3, 32'h11223344);
    #1;
    reset = 1'b0;
    #1;
    check_reset_state("midrst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_rvalid", i3.resp_valid, 0);
      check("post_rst_en", i3.data_memory_interface_enable, 0);
    end
    i3.req_valid = 1'b1; i3.req_write = 1'b0; i3.req_size = 2'd2; i3.req_address = 32'h84;
    check("post_rst_ready", i3.req_ready, 1);
    @(posedge clk);
    #1;
    i3.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_acc", i3.data_memory_interface_enable, 1);
    end
    @(negedge clk);
    check("post_rst_rsp", i3.resp_valid, 1);
    check("post_rst_rdata", i3.resp_rdata, 32'hCAFEF00D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
